// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit.
// Holds the access-size encodings, the FSM state constants and the helpers that
// compute byte masks, store-lane replication and load extraction/extension.
// The helpers assume a 32-bit word with four byte lanes.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic ST_IDLE      = 1'b0;
  localparam logic ST_LOAD_WAIT = 1'b1;

  // Reserved size 2'b11 is reported as misaligned so it never reaches the SRAM.
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_mask(logic [1:0] size, logic [1:0] off);
    case (size)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the data across lanes lets the byte mask alone pick the target lane.
  function automatic logic [31:0] replicate_store(logic [31:0] data, logic [1:0] size);
    case (size)
      SZ_B:    return {4{data[7:0]}};
      SZ_H:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(logic [31:0] word, logic [1:0] size,
                                              logic [1:0] off, logic is_unsigned);
    logic [31:0] shifted;
    shifted = word >> {off, 3'b000};
    case (size)
      SZ_B:    return is_unsigned ? {24'h0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    return is_unsigned ? {16'h0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response bus between the MEM pipeline stage and the load/store unit.
//  master: pipeline side, drives req_* and flush, receives stall/load_valid/rdata/misalign.
//  slave : load/store unit side.
interface dmem_lsu_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            flush;
  logic            stall;
  logic            load_valid;
  logic [XLEN-1:0] rdata;
  logic            misalign;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, flush,
    input  stall, load_valid, rdata, misalign
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, flush,
    output stall, load_valid, rdata, misalign
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit.
//  st_size_i/st_off_i/st_wdata_i : store request -> st_mask_o (byte enables), st_di_o
//  ld_size_i/ld_off_i/ld_unsigned_i/ld_word_i : latched load info + SRAM word -> ld_data_o
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_mask_o,
  output logic [31:0] st_di_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  always_comb begin
    st_mask_o = byte_mask(st_size_i, st_off_i);
    st_di_o   = replicate_store(st_wdata_i, st_size_i);
    ld_data_o = extend_load(ld_word_i, ld_size_i, ld_off_i, ld_unsigned_i);
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the MEM stage and a word-addressed, byte-enabled SRAM
// with one-cycle registered read data.
//  clk, rst     : clock, asynchronous active-high reset
//  bus          : pipeline request/response (dmem_lsu_if.slave)
//  sram_addr    : word address from req_addr[WORD_ADDR_BITS+1:2]
//  sram_read    : read strobe (loads, in IDLE)
//  sram_write   : byte write enables (stores, in IDLE)
//  sram_di      : lane-replicated store data
//  sram_do      : SRAM read data, only looked at in LOAD_WAIT
// Stores complete in one cycle; loads stall one cycle, then pulse load_valid.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned WORD_ADDR_BITS = 14,
  parameter int unsigned XLEN           = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  dmem_lsu_if.slave                 bus,
  output logic [WORD_ADDR_BITS-1:0] sram_addr,
  output logic                      sram_read,
  output logic [3:0]                sram_write,
  output logic [XLEN-1:0]           sram_di,
  input  logic [XLEN-1:0]           sram_do
);

  logic            state_q, state_d;
  logic [1:0]      off_q, off_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic [3:0]      st_mask;
  logic [XLEN-1:0] ld_data;
  logic            req_misaligned;

  // Upper address bits wrap within the SRAM.
  logic unused_addr;
  assign unused_addr = ^bus.req_addr[XLEN-1:WORD_ADDR_BITS+2];

  assign sram_addr      = bus.req_addr[WORD_ADDR_BITS+1:2];
  assign req_misaligned = is_misaligned(bus.req_size, bus.req_addr[1:0]);

  lsu_align u_align (
    .st_size_i     (bus.req_size),
    .st_off_i      (bus.req_addr[1:0]),
    .st_wdata_i    (bus.req_wdata),
    .st_mask_o     (st_mask),
    .st_di_o       (sram_di),
    .ld_size_i     (size_q),
    .ld_off_i      (off_q),
    .ld_unsigned_i (uns_q),
    .ld_word_i     (sram_do),
    .ld_data_o     (ld_data)
  );

  always_comb begin
    state_d        = state_q;
    off_d          = off_q;
    size_d         = size_q;
    uns_d          = uns_q;
    rdata_d        = rdata_q;
    bus.stall      = 1'b0;
    bus.load_valid = 1'b0;
    bus.misalign   = 1'b0;
    sram_read      = 1'b0;
    sram_write     = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        // rst gating keeps all outputs at reset values while reset is held.
        if (bus.req_valid && !bus.flush && !rst) begin
          if (req_misaligned) begin
            bus.misalign = 1'b1;
          end else if (bus.req_we) begin
            sram_write = st_mask;
          end else begin
            sram_read = 1'b1;
            bus.stall = 1'b1;
            off_d     = bus.req_addr[1:0];
            size_d    = bus.req_size;
            uns_d     = bus.req_unsigned;
            state_d   = ST_LOAD_WAIT;
          end
        end
      end
      ST_LOAD_WAIT: begin
        state_d = ST_IDLE;
        if (!bus.flush) begin
          bus.load_valid = 1'b1;
          rdata_d        = ld_data;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    bus.rdata = bus.load_valid ? ld_data : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      off_q   <= 2'b00;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized self-checking bench for dmem_lsu against a byte-addressed memory model.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] sram_addr;
  logic        sram_read;
  logic [3:0]  sram_write;
  logic [31:0] sram_di;
  logic [31:0] sram_do;

  dmem_lsu_if #(.XLEN(32)) bus ();

  dmem_lsu #(
    .WORD_ADDR_BITS (14),
    .XLEN           (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sram_addr  (sram_addr),
    .sram_read  (sram_read),
    .sram_write (sram_write),
    .sram_di    (sram_di),
    .sram_do    (sram_do)
  );

  always #5 clk = ~clk;

  // SRAM: registered read data; garbage when no read was issued.
  logic [31:0] sram_mem [0:16383];
  always @(posedge clk) begin
    if (sram_read) sram_do <= sram_mem[sram_addr];
    else           sram_do <= $urandom();
    for (int i = 0; i < 4; i++)
      if (sram_write[i]) sram_mem[sram_addr][8*i +: 8] <= sram_di[8*i +: 8];
  end

  // Reference: flat byte memory over the first 1 KiB of the address space.
  logic [7:0]  ref_mem [0:1023];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_rdata = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic ref_misaligned(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
    return (a % (32'd1 << sz)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic uns);
    int          n;
    logic [31:0] v;
    n = 1 << sz;
    v = 32'h0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[int'(a[9:0]) + k];
    if (!uns && v[8*n-1])
      for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.flush        = 1'b0;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] sz, input logic we,
                       input logic uns, input logic [31:0] d, input logic fl);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = d;
    bus.flush        = fl;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int          n;
    logic [3:0]  m;
    logic [31:0] di;
    n = 1 << sz;
    m = 4'b0;
    for (int k = 0; k < n; k++) m[int'(a[1:0]) + k] = 1'b1;
    for (int i = 0; i < 4; i++) di[8*i +: 8] = d[8*(i % n) +: 8];
    @(negedge clk);
    drive(a, sz, 1'b1, 1'b0, d, 1'b0);
    #2;
    check_eq("st_mask",  32'(sram_write), 32'(m));
    check_eq("st_di",    sram_di, di);
    check_eq("st_addr",  32'(sram_addr), 32'(a[15:2]));
    check_eq("st_stall", 32'(bus.stall), 32'h0);
    check_eq("st_read",  32'(sram_read), 32'h0);
    for (int k = 0; k < n; k++) ref_mem[int'(a[9:0]) + k] = d[8*k +: 8];
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                         input logic fl);
    logic [31:0] exp;
    exp = ref_load(a, sz, uns);
    @(negedge clk);
    drive(a, sz, 1'b0, uns, $urandom(), 1'b0);
    #2;
    check_eq("ld_stall", 32'(bus.stall), 32'h1);
    check_eq("ld_read",  32'(sram_read), 32'h1);
    check_eq("ld_write", 32'(sram_write), 32'h0);
    check_eq("ld_addr",  32'(sram_addr), 32'(a[15:2]));
    // Request inputs are don't-care while waiting; scramble them.
    @(negedge clk);
    drive($urandom(), 2'($urandom()), 1'($urandom()), 1'($urandom()), $urandom(), fl);
    bus.req_valid = 1'($urandom());
    #2;
    check_eq("ld_valid", 32'(bus.load_valid), fl ? 32'h0 : 32'h1);
    check_eq("ld_rdata", bus.rdata, fl ? last_rdata : exp);
    check_eq("ld_wstall", 32'(bus.stall), 32'h0);
    check_eq("ld_wacc",  32'({sram_read, sram_write, bus.misalign}), 32'h0);
    if (!fl) last_rdata = exp;
    @(negedge clk);
    idle_inputs();
    #2;
    check_eq("ld_hold",  bus.rdata, last_rdata);
    check_eq("ld_pulse", 32'(bus.load_valid), 32'h0);
  endtask

  task automatic do_misalign(input logic [31:0] a, input logic [1:0] sz, input logic we);
    @(negedge clk);
    drive(a, sz, we, 1'b0, $urandom(), 1'b0);
    #2;
    check_eq("mis_flag",  32'(bus.misalign), 32'h1);
    check_eq("mis_acc",   32'({sram_read, sram_write, bus.stall}), 32'h0);
  endtask

  task automatic do_flush_idle(input logic [31:0] a, input logic [1:0] sz, input logic we);
    @(negedge clk);
    drive(a, sz, we, 1'b0, $urandom(), 1'b1);
    #2;
    check_eq("fl_acc", 32'({sram_read, sram_write, bus.stall, bus.misalign}), 32'h0);
    @(negedge clk);
    idle_inputs();
    #2;
    check_eq("fl_novalid", 32'(bus.load_valid), 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          r;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check_eq("rst_out", 32'({bus.stall, bus.load_valid, bus.misalign, sram_read, sram_write}),
             32'h0);
    check_eq("rst_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int w = 0; w < 256; w++) do_store(32'(w * 4), 2'd2, $urandom());

    do_store(32'h103, 2'd0, 32'h0000_00AB);
    check_eq("sb_addr", 32'(sram_addr), 32'h40);
    check_eq("sb_mask", 32'(sram_write), 32'h8);
    check_eq("sb_di",   sram_di, 32'hABAB_ABAB);

    do_store(32'h200, 2'd2, 32'h80FF_7F01);
    do_load(32'h201, 2'd0, 1'b0, 1'b0);
    check_eq("lb_201",  last_rdata, 32'h0000_007F);
    do_load(32'h203, 2'd0, 1'b0, 1'b0);
    check_eq("lb_203",  last_rdata, 32'hFFFF_FF80);
    do_load(32'h203, 2'd0, 1'b1, 1'b0);
    check_eq("lbu_203", last_rdata, 32'h0000_0080);
    do_load(32'h202, 2'd1, 1'b0, 1'b0);
    check_eq("lh_202",  last_rdata, 32'hFFFF_80FF);
    do_load(32'h200, 2'd2, 1'b0, 1'b0);
    check_eq("lw_200",  last_rdata, 32'h80FF_7F01);

    do_misalign(32'h101, 2'd1, 1'b0);
    do_misalign(32'h102, 2'd2, 1'b1);
    do_misalign(32'h100, 2'd3, 1'b0);
    do_flush_idle(32'h101, 2'd1, 1'b0);
    do_flush_idle(32'h200, 2'd2, 1'b0);

    do_load(32'h200, 2'd2, 1'b0, 1'b1);

    do_store(32'h300, 2'd2, 32'h1234_5678);
    do_load(32'h300, 2'd2, 1'b0, 1'b0);
    check_eq("sw_lw_300", last_rdata, 32'h1234_5678);

    // Reset while waiting on a load.
    @(negedge clk);
    drive(32'h100, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #2;
    check_eq("rstw_valid", 32'(bus.load_valid), 32'h0);
    check_eq("rstw_rdata", bus.rdata, 32'h0);
    check_eq("rstw_stall", 32'(bus.stall), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    last_rdata = 32'h0;
    @(negedge clk);
    #2;
    check_eq("rstw_idle", 32'(bus.load_valid), 32'h0);

    for (int it = 0; it < 400; it++) begin
      a  = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 1023));
      sz = 2'($urandom_range(0, 3));
      r  = $urandom_range(0, 9);
      if (r == 0)                         do_flush_idle(a, sz, 1'($urandom()));
      else if (ref_misaligned(a, sz))     do_misalign(a, sz, 1'($urandom()));
      else if (r < 5)                     do_store(a, sz, $urandom());
      else do_load(a, sz, 1'($urandom()), ($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
